// File: rtl/led_pattern_sched.sv
// led_pattern_sched: debounced key steps OFF/MIRROR/RUN/BLINK modes and drives an 8-bit LED bar
// from a pattern table, advanced by a TICK_DIV prescaler.
module led_pattern_sched #(
  parameter int TICK_DIV = 12500000,
  parameter int DEB_CYC  = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       run,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYC);
  localparam logic [63:0] MIRROR_TAB = 64'h00_81_42_24_18_24_42_81;
  typedef enum logic [1:0] {OFF, MIRROR, RUN, BLINK} mode_e;
  mode_e          mode_q, mode_d;
  logic           s1_q, s2_q, key_q, key_d;
  logic [DW-1:0]  deb_q, deb_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [2:0]     step_q, step_d, step_nx;
  logic [7:0]     led_q, led_d, pat;
  logic           deb_done, press, active;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      key_q  <= 1'b1;
      deb_q  <= '0;
      pre_q  <= '0;
      step_q <= '0;
      led_q  <= '0;
      mode_q <= OFF;
    end else begin
      s1_q   <= key_n;
      s2_q   <= s1_q;
      key_q  <= key_d;
      deb_q  <= deb_d;
      pre_q  <= pre_d;
      step_q <= step_d;
      led_q  <= led_d;
      mode_q <= mode_d;
    end
  // press fires in the cycle the debounced level is about to fall, so the mode moves on that same edge
  always_comb begin
    deb_done = deb_q == DW'(DEB_CYC - 1);
    key_d    = (s2_q != key_q && deb_done) ? s2_q : key_q;
    deb_d    = (s2_q == key_q || deb_done) ? '0 : deb_q + DW'(1);
    press    = key_q && !s2_q && deb_done;
    active   = run && mode_q != OFF;
    tick     = active && pre_q == PW'(TICK_DIV - 1) && !press;
    pre_d    = (!active || press || tick) ? '0 : pre_q + PW'(1);
    mode_d   = press ? mode_e'(mode_q + 2'd1) : mode_q;
    pat      = mode_q == MIRROR ? MIRROR_TAB[{step_q, 3'b000} +: 8] :
               mode_q == RUN    ? 8'h01 << step_q : {8{~step_q[0]}};
    step_nx  = mode_q == BLINK ? {2'b00, ~step_q[0]} : step_q + 3'd1;
    step_d   = press ? 3'd0 : tick ? step_nx : step_q;
    led_d    = (press || mode_q == OFF) ? 8'h00 : tick ? pat : led_q;
  end
  assign led  = led_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: table-driven plan vectors, hand corner sequences and random stimulus,
// all checked every cycle against a windowed-history behavioural model.
module tb_led_pattern_sched;
  localparam int TICK_DIV = 4;
  localparam int DEB_CYC  = 8;
  typedef struct {int n; bit key; bit run; logic [7:0] led; logic [1:0] mode;} vec_t;
  logic clk = 1'b0, rst_n = 1'b1, key_n = 1'b1, run = 1'b1;
  logic [7:0] led;
  logic [1:0] mode;
  logic tick;
  int vec_n = 0, bad_n = 0;
  bit hist[$];
  bit m_deb;
  int m_mode, m_step, m_pc;
  logic [7:0] m_led;
  logic [7:0] mirror_t[8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81, 8'h00};
  logic [7:0] run_t[8]    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] blink_t[2]  = '{8'hFF, 8'h00};
  led_pattern_sched #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .run(run), .led(led), .mode(mode), .tick(tick));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vec_n++;
    if (a !== e) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    repeat (DEB_CYC + 4) hist.push_back(1'b1);
    m_deb = 1'b1; m_mode = 0; m_step = 0; m_pc = 0; m_led = 8'h00;
  endtask
  // the debounced level flips once the synchronised key (key_n two samples back) has held the
  // opposite value for DEB_CYC consecutive samples
  function automatic bit flip_now();
    int n = hist.size();
    for (int i = n - 1 - DEB_CYC; i <= n - 2; i++)
      if (hist[i] == m_deb) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [7:0] pattern(input int md, input int st);
    return md == 1 ? mirror_t[st] : md == 2 ? run_t[st] : blink_t[st];
  endfunction
  task automatic cycle(input bit k, input bit r, output logic t);
    bit fl, pm, tm;
    @(negedge clk);
    key_n = k; run = r;
    #1;
    fl = flip_now();
    pm = fl && m_deb;
    tm = r && m_mode != 0 && m_pc == TICK_DIV - 1 && !pm;
    t = tick;
    chk("tick", tick, tm);
    chk("led", led, m_led);
    chk("mode", mode, m_mode);
    @(posedge clk);
    if (fl) m_deb = !m_deb;
    hist.push_back(k);
    if (hist.size() > 64) void'(hist.pop_front());
    if (pm) begin
      m_mode = (m_mode + 1) % 4; m_step = 0; m_pc = 0; m_led = 8'h00;
    end else if (m_mode == 0) begin
      m_led = 8'h00; m_pc = 0;
    end else if (!r) m_pc = 0;
    else if (tm) begin
      m_led = pattern(m_mode, m_step);
      m_step = (m_step + 1) % (m_mode == 3 ? 2 : 8);
      m_pc = 0;
    end else m_pc++;
  endtask
  task automatic cyc(input bit k, input bit r, input int n);
    logic t;
    repeat (n) cycle(k, r, t);
  endtask
  task automatic at(input string nm, input logic [7:0] el, input logic [1:0] em);
    #2;
    chk({nm, "_led"}, led, el);
    chk({nm, "_mode"}, mode, em);
  endtask
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_led", led, 0);
    chk("rst_mode", mode, 0);
    chk("rst_tick", tick, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    vec_t tv[$];
    logic t;
    int w, n;
    bit k, r;
    tv.push_back('{100, 1'b1, 1'b1, 8'h00, 2'd0});
    tv.push_back('{10,  1'b0, 1'b1, 8'h00, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h81, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h42, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h24, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h18, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h24, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h42, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h81, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h00, 2'd1});
    tv.push_back('{4, 1'b0, 1'b1, 8'h81, 2'd1});
    do_reset();
    foreach (tv[i]) begin
      cyc(tv[i].key, tv[i].run, tv[i].n);
      at("tbl", tv[i].led, tv[i].mode);
    end
    for (int i = 0; i < 40; i++) cyc(((i / 3) % 2) == 0, 1'b1, 1);
    cyc(1'b1, 1'b1, 12);
    at("bounce", 8'h42, 2'd1);
    cyc(1'b0, 1'b1, 10); at("run_enter", 8'h00, 2'd2);
    cyc(1'b0, 1'b1, 16); at("run_08", 8'h08, 2'd2);
    cyc(1'b0, 1'b0, 20); at("frozen", 8'h08, 2'd2);
    cyc(1'b0, 1'b1, 4);  at("resume", 8'h10, 2'd2);
    cyc(1'b0, 1'b1, 16); at("run_wrap", 8'h01, 2'd2);
    cyc(1'b1, 1'b1, 12);
    cyc(1'b0, 1'b1, 10); at("blink_enter", 8'h00, 2'd3);
    cyc(1'b0, 1'b1, 4);  at("blink0", 8'hFF, 2'd3);
    cyc(1'b0, 1'b1, 4);  at("blink1", 8'h00, 2'd3);
    cyc(1'b0, 1'b1, 4);  at("blink2", 8'hFF, 2'd3);
    cyc(1'b1, 1'b1, 12);
    cyc(1'b0, 1'b1, 10); at("off_enter", 8'h00, 2'd0);
    cyc(1'b0, 1'b1, 20); at("off_hold", 8'h00, 2'd0);
    cyc(1'b1, 1'b1, 12);
    cyc(1'b0, 1'b1, 10); at("s6_enter", 8'h00, 2'd1);
    w = 0;
    while (!(m_deb && m_pc == 2) && w < 60) begin
      cyc(1'b1, 1'b1, 1);
      w++;
    end
    if (w == 60) begin
      vec_n++; bad_n++;
      $display("FAIL align_timeout: got %0d cycles want <60", w);
    end
    cyc(1'b0, 1'b1, 9);
    cycle(1'b0, 1'b1, t);
    chk("press_tick_suppr", t, 0);
    at("s6_press", 8'h00, 2'd2);
    cyc(1'b0, 1'b1, 8); at("s6_run", 8'h02, 2'd2);
    do_reset();
    for (int s = 0; s < 400; s++) begin
      k = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 7) != 0;
      n = $urandom_range(1, 14);
      if ($urandom_range(0, 59) == 0) do_reset();
      cyc(k, r, n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
    $finish;
  end
endmodule
